// File: rtl/ram_rmw_bridge_pkg.sv
// Shared definitions for the narrow-to-wide RAM read-modify-write bridge.
//   - state_t     : bridge FSM encoding
//   - CByteLen    : byte-enable granularity in bits
//   - f_lane_bits : log2 of the lane count (CDataLen / CWordLen)
package ram_rmw_bridge_pkg;

  typedef enum logic [1:0] {
    SIdle   = 2'd0,
    SRdReq  = 2'd1,
    SRdWait = 2'd2,
    SWr     = 2'd3
  } state_t;

  localparam int CByteLen = 8;

  // Lane index width. The lane count is a power of two, so this is exact.
  function automatic int f_lane_bits(input int data_len, input int word_len);
    int n;
    int b;
    n = data_len / word_len;
    b = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << b) < n) b = b + 1;
    end
    return b;
  endfunction

endpackage

// File: rtl/ram_lane_merge.sv
// Combinational lane datapath for the RMW bridge.
//   line      in  full RAM line (read data)
//   lane      in  selected word lane
//   word      in  client write word
//   be        in  client byte enables for that word
//   merged    out line with the selected lane's enabled bytes replaced by word
//   lane_word out selected lane of line (read path)
module ram_lane_merge
  import ram_rmw_bridge_pkg::*;
#(
  parameter int CDataLen = 128,
  parameter int CWordLen = 32,
  parameter int CLaneW   = 2
) (
  input  logic [CDataLen-1:0]          line,
  input  logic [CLaneW-1:0]            lane,
  input  logic [CWordLen-1:0]          word,
  input  logic [CWordLen/CByteLen-1:0] be,
  output logic [CDataLen-1:0]          merged,
  output logic [CWordLen-1:0]          lane_word
);

  localparam int NumLanes = CDataLen / CWordLen;
  localparam int NumBytes = CWordLen / CByteLen;

  logic [NumLanes-1:0][CWordLen-1:0] line_v;
  logic [NumLanes-1:0][CWordLen-1:0] merged_v;

  assign line_v = line;

  for (genvar l = 0; l < NumLanes; l++) begin : g_lane
    for (genvar b = 0; b < NumBytes; b++) begin : g_byte
      assign merged_v[l][b*CByteLen +: CByteLen] =
        (lane == CLaneW'(l) && be[b]) ? word[b*CByteLen +: CByteLen]
                                      : line_v[l][b*CByteLen +: CByteLen];
    end
  end

  assign merged    = merged_v;
  assign lane_word = line_v[lane];

endmodule

// File: rtl/ram_rmw_bridge.sv
// Narrow word client -> wide single-port RAM bridge.
// Reads fetch the line and return one lane; writes fetch, merge bytes and
// write the line back. A write skips the fetch only when the line is a
// single word wide and every byte is enabled.
// Ports:
//   AClkH, AResetHN (async low), AClkHEn   clock / reset / clock enable
//   AReqVld/AReqRdy/AReqWr/AReqAddr/AReqData/AReqBe   client request
//   ARdVld/ARdData                          read response strobe + data
//   AWrAck                                  write committed strobe
//   ARamAddr/ARamMosi/ARamMiso/ARamWrEn/ARamRdEn   wide RAM side
module ram_rmw_bridge
  import ram_rmw_bridge_pkg::*;
#(
  parameter  int CAddrLen  = 13,
  parameter  int CDataLen  = 128,
  parameter  int CWordLen  = 32,
  localparam int CLaneBits = f_lane_bits(CDataLen, CWordLen)
) (
  input  logic                          AClkH,
  input  logic                          AResetHN,
  input  logic                          AClkHEn,
  input  logic                          AReqVld,
  output logic                          AReqRdy,
  input  logic                          AReqWr,
  input  logic [CAddrLen+CLaneBits-1:0] AReqAddr,
  input  logic [CWordLen-1:0]           AReqData,
  input  logic [CWordLen/CByteLen-1:0]  AReqBe,
  output logic                          ARdVld,
  output logic [CWordLen-1:0]           ARdData,
  output logic                          AWrAck,
  output logic [CAddrLen-1:0]           ARamAddr,
  output logic [CDataLen-1:0]           ARamMosi,
  input  logic [CDataLen-1:0]           ARamMiso,
  output logic                          ARamWrEn,
  output logic                          ARamRdEn
);

  localparam int CBeLen = CWordLen / CByteLen;
  // A single-lane line has a zero-width lane field; keep a 1-bit register.
  localparam int CLaneW = (CLaneBits > 0) ? CLaneBits : 1;
  // Skipping the fetch is only safe when the word covers the whole line,
  // otherwise the other lanes would be lost.
  localparam bit CSkipOk = (CDataLen == CWordLen);

  state_t state, state_nxt;

  logic                wr_q;
  logic [CAddrLen-1:0] line_q;
  logic [CLaneW-1:0]   lane_q;
  logic [CWordLen-1:0] data_q;
  logic [CBeLen-1:0]   be_q;
  logic [CDataLen-1:0] merge_q;
  logic                rd_vld_q;
  logic [CWordLen-1:0] rd_data_q;
  logic                wr_ack_q;

  logic [CLaneW-1:0]   req_lane;
  logic [CAddrLen-1:0] req_line;
  logic                req_skip;
  logic [CDataLen-1:0] miso_merged;
  logic [CWordLen-1:0] miso_word;

  assign req_line = AReqAddr[CLaneBits +: CAddrLen];

  if (CLaneBits > 0) begin : g_lane_idx
    assign req_lane = AReqAddr[CLaneW-1:0];
  end else begin : g_lane_zero
    assign req_lane = '0;
  end

  assign req_skip = CSkipOk && AReqWr && (&AReqBe);

  ram_lane_merge #(
    .CDataLen (CDataLen),
    .CWordLen (CWordLen),
    .CLaneW   (CLaneW)
  ) u_merge (
    .line      (ARamMiso),
    .lane      (lane_q),
    .word      (data_q),
    .be        (be_q),
    .merged    (miso_merged),
    .lane_word (miso_word)
  );

  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) state <= SIdle;
    else if (AClkHEn) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    AReqRdy   = 1'b0;
    ARamRdEn  = 1'b0;
    ARamWrEn  = 1'b0;
    case (state)
      SIdle: begin
        AReqRdy = 1'b1;
        if (AReqVld) state_nxt = req_skip ? SWr : SRdReq;
      end
      SRdReq: begin
        ARamRdEn  = 1'b1;
        state_nxt = SRdWait;
      end
      SRdWait: state_nxt = wr_q ? SWr : SIdle;
      SWr: begin
        ARamWrEn  = 1'b1;
        state_nxt = SIdle;
      end
      default: state_nxt = SIdle;
    endcase
  end

  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      wr_q      <= 1'b0;
      line_q    <= '0;
      lane_q    <= '0;
      data_q    <= '0;
      be_q      <= '0;
      merge_q   <= '0;
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
      wr_ack_q  <= 1'b0;
    end else if (AClkHEn) begin
      // Response strobes are single-cycle; data returns to 0 when not valid.
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
      wr_ack_q  <= 1'b0;
      case (state)
        SIdle: begin
          if (AReqVld) begin
            wr_q   <= AReqWr;
            line_q <= req_line;
            lane_q <= req_lane;
            data_q <= AReqData;
            be_q   <= AReqBe;
            // Skip path only exists for single-lane lines: the word is the line.
            if (req_skip) merge_q <= CDataLen'(AReqData);
          end
        end
        SRdWait: begin
          if (wr_q) begin
            merge_q <= miso_merged;
          end else begin
            rd_vld_q  <= 1'b1;
            rd_data_q <= miso_word;
          end
        end
        SWr: wr_ack_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign ARdVld   = rd_vld_q;
  assign ARdData  = rd_data_q;
  assign AWrAck   = wr_ack_q;
  assign ARamAddr = line_q;
  assign ARamMosi = merge_q;

endmodule
